// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, MixColumns coefficients and the
// sequencer state type.
package aes_pkg;

    localparam int unsigned NB = 4;

    // Element [NB-1] is the first coefficient of matrix row 0.
    localparam logic [NB-1:0][7:0] FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [NB-1:0][7:0] INV_COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } mcs_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Intended for constant k so synthesis folds it into a few xtime/xor stages.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] pow;
        acc = 8'h00;
        pow = b;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) acc = acc ^ pow;
            pow = xtime(pow);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational (Inv)MixColumns on one 32-bit column; byte 0 is the MSB.
module mix_column_unit
    import aes_pkg::*;
#(
    parameter bit INVERSE_EN = 1'b1
) (
    input  logic [31:0] col_i,
    input  logic        inv_i,
    output logic [31:0] col_o
);

    // Output byte r uses the coefficient row rotated right by r.
    function automatic logic [31:0] mix(input logic [31:0] col,
                                        input logic [NB-1:0][7:0] coef);
        logic [NB-1:0][7:0] a;
        logic [NB-1:0][7:0] b;
        a = col;
        for (int r = 0; r < NB; r++) begin
            b[NB-1-r] = 8'h00;
            for (int j = 0; j < NB; j++) begin
                b[NB-1-r] = b[NB-1-r] ^ gf_mul(a[NB-1-j], coef[NB-1-((j-r+NB)%NB)]);
            end
        end
        return b;
    endfunction

    logic [31:0] fwd;
    assign fwd = mix(col_i, FWD_COEF);

    generate
        if (INVERSE_EN) begin : g_inv
            assign col_o = inv_i ? mix(col_i, INV_COEF) : fwd;
        end else begin : g_fwd_only
            logic unused_inv;
            assign unused_inv = inv_i;
            assign col_o      = fwd;
        end
    endgenerate

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns/InvMixColumns over a 128-bit AES state with a
// valid/ready handshake on both sides; COLS_PER_CYCLE columns per clock.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1,
    parameter bit          INVERSE_EN     = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $fatal(1, "mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [2:0] STEP     = 3'(COLS_PER_CYCLE);
    localparam logic [2:0] DONE_CNT = 3'(NB);

    mcs_state_e           state_q, state_d;
    logic [NB-1:0][31:0]  data_q, data_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 mode_q, mode_d;

    logic accept;
    logic inv_sel;

    logic [1:0]  col_pos [COLS_PER_CYCLE];
    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign inv_sel   = in_inv && INVERSE_EN;
    assign out_valid = (state_q == StDone);
    assign out_data  = data_q;

    // Column c lives in data_q[NB-1-c]; units cover columns cnt_q .. cnt_q+k.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
        assign col_pos[k] = 2'd3 - (cnt_q[1:0] + 2'(k));
        assign col_in[k]  = data_q[col_pos[k]];

        mix_column_unit #(
            .INVERSE_EN (INVERSE_EN)
        ) u_unit (
            .col_i (col_in[k]),
            .inv_i (mode_q),
            .col_o (col_out[k])
        );
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        unique case (state_q)
            StIdle: ;
            StBusy: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    data_d[col_pos[k]] = col_out[k];
                end
                cnt_d = cnt_q + STEP;
                if (cnt_d == DONE_CNT) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Accept is only possible in IDLE or on the DONE handshake cycle.
        if (accept) begin
            data_d  = in_data;
            mode_d  = inv_sel;
            cnt_d   = 3'd0;
            state_d = StBusy;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= 3'd0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Checks four configurations side by side (1/2/4 columns per cycle with
// inverse, 1 column forward-only) against a GF(2^8) matrix model.
module tb_mix_columns_seq;

    typedef logic [127:0] blk4_t [4];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_ready;

    logic         ov [4];
    logic         ir [4];
    logic [127:0] od [4];

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_lat [4]  = '{4, 2, 1, 4};
    bit dut_inv [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    mix_columns_seq #(.COLS_PER_CYCLE(1), .INVERSE_EN(1'b1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]));
    mix_columns_seq #(.COLS_PER_CYCLE(2), .INVERSE_EN(1'b1)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]));
    mix_columns_seq #(.COLS_PER_CYCLE(4), .INVERSE_EN(1'b1)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]));
    mix_columns_seq #(.COLS_PER_CYCLE(1), .INVERSE_EN(1'b0)) u_fwd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]));

    // Schoolbook carry-less product, then reduction by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] m_gf(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
        logic [7:0]   row [4];
        logic [7:0]   a   [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv) row = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     row = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ m_gf(row[(j - r) & 3], a[j]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic blk4_t expect_all(input logic [127:0] s, input bit inv);
        blk4_t e;
        for (int d = 0; d < 4; d++) e[d] = ref_mix(s, inv && dut_inv[d]);
        return e;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watches every DUT for its first out_valid after the accept edge just taken.
    task automatic wait_results(input blk4_t exp, input string name);
        bit seen [4];
        int lat  [4];
        for (int d = 0; d < 4; d++) begin
            seen[d] = 1'b0;
            lat[d]  = 0;
        end
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            for (int d = 0; d < 4; d++) begin
                if (!seen[d] && ov[d] === 1'b1) begin
                    seen[d] = 1'b1;
                    lat[d]  = cyc;
                    tests_run++;
                    if (od[d] !== exp[d]) begin
                        tests_failed++;
                        $display("FAIL %s data dut%0d: got %h expected %h", name, d, od[d],
                                 exp[d]);
                    end
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (!seen[d] || lat[d] != exp_lat[d]) begin
                tests_failed++;
                $display("FAIL %s latency dut%0d: got %0d (seen=%0d) expected %0d", name, d,
                         lat[d], seen[d], exp_lat[d]);
            end
        end
    endtask

    task automatic run_block(input logic [127:0] s, input bit inv, input blk4_t exp,
                             input string name);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = s;
        in_inv    = inv;
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (ir[d] !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s in_ready dut%0d: got %b expected 1", name, d, ir[d]);
            end
        end
        tick();
        in_valid = 1'b0;
        in_data  = rand128();
        in_inv   = ~inv;
        wait_results(exp, name);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 4; d++) begin
            tests_run += 3;
            if (ov[d] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset out_valid dut%0d: got %b expected 0", d, ov[d]);
            end
            if (od[d] !== 128'h0) begin
                tests_failed++;
                $display("FAIL reset out_data dut%0d: got %h expected 0", d, od[d]);
            end
            if (ir[d] !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset in_ready dut%0d: got %b expected 1", d, ir[d]);
            end
        end
    endtask

    task automatic test_vectors();
        logic [127:0] fwd_in, fwd_out, inv_in, inv_out;
        blk4_t e;
        fwd_in  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        fwd_out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        inv_in  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
        inv_out = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
        for (int d = 0; d < 4; d++) e[d] = fwd_out;
        run_block(fwd_in, 1'b0, e, "fwd_vector");
        for (int d = 0; d < 3; d++) e[d] = inv_out;
        e[3] = ref_mix(inv_in, 1'b0);
        run_block(inv_in, 1'b1, e, "inv_vector");
        // Forward-only build must ignore in_inv entirely.
        e = expect_all(fwd_in, 1'b1);
        e[3] = fwd_out;
        run_block(fwd_in, 1'b1, e, "inv_tied_off");
    endtask

    task automatic test_random();
        logic [127:0] s;
        bit inv;
        for (int n = 0; n < 20; n++) begin
            s   = rand128();
            inv = 1'($urandom_range(0, 1));
            run_block(s, inv, expect_all(s, inv), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, c;
        bit a_inv, c_inv;
        blk4_t ea;
        a     = rand128();
        a_inv = 1'b1;
        c     = rand128();
        c_inv = 1'b0;
        ea    = expect_all(a, a_inv);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = a;
        in_inv    = a_inv;
        tick();
        for (int i = 0; i < 4; i++) begin
            in_data = rand128();
            in_inv  = 1'($urandom_range(0, 1));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            in_data = rand128();
            in_inv  = 1'($urandom_range(0, 1));
            #1;
            for (int d = 0; d < 4; d++) begin
                tests_run += 3;
                if (ov[d] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stall out_valid dut%0d: got %b expected 1", d, ov[d]);
                end
                if (od[d] !== ea[d]) begin
                    tests_failed++;
                    $display("FAIL stall out_data dut%0d: got %h expected %h", d, od[d], ea[d]);
                end
                if (ir[d] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stall in_ready dut%0d: got %b expected 0", d, ir[d]);
                end
            end
            tick();
        end
        in_data   = c;
        in_inv    = c_inv;
        out_ready = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            tests_run++;
            if (ir[d] !== 1'b1) begin
                tests_failed++;
                $display("FAIL release in_ready dut%0d: got %b expected 1", d, ir[d]);
            end
        end
        tick();
        in_valid = 1'b0;
        in_data  = rand128();
        wait_results(expect_all(c, c_inv), "back_to_back");
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] s;
        s         = rand128();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = rand128();
        in_inv    = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            tests_run += 3;
            if (ov[d] !== 1'b0) begin
                tests_failed++;
                $display("FAIL abort out_valid dut%0d: got %b expected 0", d, ov[d]);
            end
            if (od[d] !== 128'h0) begin
                tests_failed++;
                $display("FAIL abort out_data dut%0d: got %h expected 0", d, od[d]);
            end
            if (ir[d] !== 1'b1) begin
                tests_failed++;
                $display("FAIL abort in_ready dut%0d: got %b expected 1", d, ir[d]);
            end
        end
        run_block(s, 1'b0, expect_all(s, 1'b0), "after_abort");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, meaning columns transformed per clock; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter INVERSE_EN, default 1, meaning 1 builds the InvMixColumns datapath and 0 builds forward only.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning in_data and in_inv are valid.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts a state this cycle.
REQ-007 SHALL have port in_data  input  128  meaning AES state; column c occupies bits [127-32c -: 32], byte 0 of each column is its MSB.
REQ-008 SHALL have port in_inv  input  1  meaning 1 selects InvMixColumns and 0 selects MixColumns.
REQ-009 SHALL have port out_valid  output  1  meaning out_data holds a finished result.
REQ-010 SHALL have port out_ready  input  1  meaning the consumer takes out_data.
REQ-011 SHALL have port out_data  output  128  meaning the transformed state, same packing as in_data.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL define accept = in_valid && in_ready, and in_ready = (IDLE) || (DONE && out_ready); this combinational path from out_ready is intended.
REQ-014 SHALL, on accept, register in_data, latch the mode (in_inv && INVERSE_EN), clear the column counter and enter BUSY.
REQ-015 SHALL, in BUSY, replace COLS_PER_CYCLE columns per cycle in place, lowest column index first, and advance the counter by COLS_PER_CYCLE.
REQ-016 SHALL enter DONE after 4/COLS_PER_CYCLE BUSY cycles, i.e. out_valid rises exactly 4/COLS_PER_CYCLE cycles after the accept edge.
REQ-017 SHALL hold out_valid and out_data stable in DONE until out_valid && out_ready.
REQ-018 SHALL, on output handshake, go to IDLE, or to BUSY with the new state when accept occurs in the same cycle (back-to-back, no bubble).
REQ-019 SHALL ignore in_valid while BUSY or stalled in DONE; in_data and in_inv are not sampled then.
REQ-020 SHALL ignore any in_inv change after accept; the mode is fixed per block.
REQ-021 SHALL compute forward columns with matrix rows {02,03,01,01} rotated right per output byte, over GF(2^8) with reduction polynomial 0x11B.
REQ-022 SHALL compute inverse columns with rows {0e,0b,0d,09} rotated likewise.
REQ-023 SHALL tie in_inv off internally and build no inverse logic when INVERSE_EN=0.
REQ-024 SHALL keep out_valid low in IDLE and BUSY; out_data is don't-care then but SHALL not glitch while out_valid is high.

Reset
REQ-025 SHALL, with rst_n low at a clock edge, set state to IDLE, out_valid to 0, out_data and the column counter to 0, and the mode to forward.
REQ-026 SHALL abort any BUSY or DONE block on reset with no output handshake; in_ready SHALL be 1 from the first cycle after reset is released.

Structure
REQ-027 SHALL take xtime, gf_mul-by-constant functions, NB=4 and the coefficient constants from shared package aes_pkg.
REQ-028 SHALL instantiate COLS_PER_CYCLE copies of sub-module mix_column_unit (32-bit column, forward/inverse select, purely combinational).
REQ-029 SHALL fail elaboration for COLS_PER_CYCLE not in {1,2,4}.

Verification
REQ-030 SHALL verify forward: columns db135345, f20a225c, 01010101, c6c6c6c6 -> 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6.
REQ-031 SHALL verify inverse: in_inv=1 on 8e4da1bc 9fdc589d d5d5d7d6 4d7ebdf8 -> db135345 f20a225c d4d4d4d5 2d26314c.
REQ-032 SHALL verify latency for COLS_PER_CYCLE=1, 2 and 4: out_valid rises 4, 2 and 1 cycles after accept.
REQ-033 SHALL verify backpressure: with out_ready low for 5 cycles, out_data is stable, in_ready is 0 and in_valid is ignored; raising out_ready with in_valid high gives a same-cycle accept and re-entry to BUSY.
REQ-034 SHALL verify reset: rst_n low for one cycle mid-BUSY gives out_valid=0, out_data=0 and in_ready=1 on release, then the next block computes correctly.
REQ-035 SHALL verify INVERSE_EN=0: in_inv=1 on db135345... still yields the forward result 8e4da1bc....
